// File: rtl/mc_ctrl_sequencer.sv
// rtl/mc_ctrl_sequencer.sv - multi-cycle FETCH/DECODE/EXE/MEM/WB control sequencer
module mc_ctrl_sequencer #(
  parameter int CTRL_WIDTH      = 32,
  parameter int INST_WIDTH      = 32,
  parameter int WAIT_MAX        = 15,
  parameter int SKIP_MEM        = 1,
  parameter int HALT_ON_ILLEGAL = 1,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [INST_WIDTH-1:0] INSTRUCTION,
  input  logic                  MEM_ACK,
  input  logic                  ZERO,
  output logic [CTRL_WIDTH-1:0] CTRL,
  output logic                  READ,
  output logic                  WRITE,
  output logic [2:0]            STATE,
  output logic                  ILLEGAL,
  output logic                  TIMEOUT,
  output logic [CNT_WIDTH-1:0]  RETIRED
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'b000,
    S_DECODE = 3'b001,
    S_EXE    = 3'b010,
    S_MEM    = 3'b011,
    S_WB     = 3'b100,
    S_HALT   = 3'b111
  } state_t;

  localparam logic [7:0]  WAIT_LIM = 8'(WAIT_MAX);
  localparam logic [31:0] W_FETCH  = 32'h2000_0020;
  localparam logic [31:0] W_DECODE = 32'h0000_0110;
  localparam logic [31:0] W_NOP_WB = 32'h0000_000B;

  state_t                 state_q, state_d;
  logic                   boot_q, boot_d;
  logic [7:0]             wait_q, wait_d;
  logic [5:0]             op_q, op_d;
  logic [5:0]             fn_q, fn_d;
  logic                   zero_q, zero_d;
  logic                   ill_q, ill_d;
  logic                   to_q, to_d;
  logic [CNT_WIDTH-1:0]   ret_q, ret_d;
  logic [CTRL_WIDTH-1:0]  ctrl_q, ctrl_d;
  logic                   rd_q, rd_d;
  logic                   wr_q, wr_d;

  logic                   legal, is_mem, is_rd, is_wr, zero_eff;
  logic [31:0]            exe_w, mem_w, wb_w, ctrl_w;

  // Only opcode and funct are kept; the middle instruction fields never influence control.
  logic unused_inst;
  assign unused_inst = ^INSTRUCTION[INST_WIDTH-7:6];

  // The branch WB word is registered on the EXE exit edge itself, so use the live flag there.
  assign zero_eff = (state_q == S_EXE) ? ZERO : zero_q;

  always_comb begin
    legal  = 1'b0;
    is_mem = 1'b0;
    is_rd  = 1'b0;
    is_wr  = 1'b0;
    exe_w  = 32'h0;
    mem_w  = 32'h0;
    wb_w   = W_NOP_WB;
    case (op_q)
      6'h00: begin
        exe_w = 32'h0060_1500;
        wb_w  = 32'h0060_930B;
        case (fn_q)
          6'h20, 6'h22, 6'h2C, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h01, 6'h02, 6'h00: legal = 1'b1;
          6'h08: begin
            legal = 1'b1;
            exe_w = 32'h0;
            wb_w  = 32'h0000_0001;
          end
          default: ;
        endcase
      end
      6'h08, 6'h1D, 6'h0C, 6'h0D, 6'h0A, 6'h0F: begin
        legal = 1'b1;
        exe_w = 32'h0048_1500;
        wb_w  = 32'h0048_930B;
      end
      6'h04: begin
        legal = 1'b1;
        exe_w = 32'h00A0_1500;
        wb_w  = zero_eff ? 32'h00A0_150D : 32'h00A0_150B;
      end
      6'h05: begin
        legal = 1'b1;
        exe_w = 32'h00A0_1500;
        wb_w  = zero_eff ? 32'h00A0_150B : 32'h00A0_150D;
      end
      6'h23: begin
        legal = 1'b1; is_mem = 1'b1; is_rd = 1'b1;
        exe_w = 32'h0048_1500; mem_w = 32'h0048_1520; wb_w = 32'h0048_B70B;
      end
      6'h2B: begin
        legal = 1'b1; is_mem = 1'b1; is_wr = 1'b1;
        exe_w = 32'h0048_0100; mem_w = 32'h0048_0140;
      end
      6'h1B: begin
        legal = 1'b1; is_mem = 1'b1; is_wr = 1'b1;
        exe_w = 32'h1092_0180; mem_w = 32'h1092_01C0;
      end
      6'h1C: begin
        legal = 1'b1; is_mem = 1'b1; is_rd = 1'b1;
        exe_w = 32'h005A_0100; mem_w = 32'h005A_0120;
      end
      6'h02: begin legal = 1'b1; wb_w = 32'h0000_0801; end
      6'h03: begin legal = 1'b1; wb_w = 32'h0000_0A01; end
      default: ;
    endcase
    // An unknown instruction that is allowed to run behaves as a plain NOP.
    if (!legal) begin
      is_mem = 1'b0;
      is_rd  = 1'b0;
      is_wr  = 1'b0;
      exe_w  = 32'h0;
      mem_w  = 32'h0;
      wb_w   = W_NOP_WB;
    end
  end

  always_comb begin
    state_d = state_q;
    boot_d  = 1'b1;
    wait_d  = wait_q;
    op_d    = op_q;
    fn_d    = fn_q;
    zero_d  = zero_q;
    ill_d   = ill_q;
    to_d    = to_q;
    ret_d   = ret_q;
    case (state_q)
      S_FETCH: begin
        // The first edge out of reset only loads the FETCH outputs.
        if (boot_q) begin
          if (MEM_ACK) begin
            op_d    = INSTRUCTION[INST_WIDTH-1 -: 6];
            fn_d    = INSTRUCTION[5:0];
            state_d = S_DECODE;
          end else if (wait_q == WAIT_LIM - 8'd1) begin
            to_d    = 1'b1;
            state_d = S_HALT;
          end else begin
            wait_d = wait_q + 8'd1;
          end
        end
      end
      S_DECODE: begin
        if (!legal && (HALT_ON_ILLEGAL != 0)) begin
          ill_d   = 1'b1;
          state_d = S_HALT;
        end else begin
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        zero_d  = ZERO;
        state_d = (is_mem || (SKIP_MEM == 0)) ? S_MEM : S_WB;
      end
      S_MEM: begin
        if (!is_mem || MEM_ACK) begin
          state_d = S_WB;
        end else if (wait_q == WAIT_LIM - 8'd1) begin
          to_d    = 1'b1;
          state_d = S_HALT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_WB: begin
        ret_d   = ret_q + CNT_WIDTH'(1);
        state_d = S_FETCH;
      end
      S_HALT: ;
      default: state_d = S_HALT;
    endcase
    if (state_d != state_q) wait_d = 8'd0;
  end

  // Outputs are computed from the next state so they change on the same edge as STATE.
  always_comb begin
    ctrl_w = 32'h0;
    rd_d   = 1'b0;
    wr_d   = 1'b0;
    case (state_d)
      S_FETCH:  begin ctrl_w = W_FETCH; rd_d = 1'b1; end
      S_DECODE: ctrl_w = W_DECODE;
      S_EXE:    ctrl_w = exe_w;
      S_MEM: begin
        if (is_mem) begin
          ctrl_w = mem_w;
          rd_d   = is_rd;
          wr_d   = is_wr;
        end else begin
          ctrl_w = exe_w;
        end
      end
      S_WB:     ctrl_w = wb_w;
      default:  ctrl_w = 32'h0;
    endcase
    ctrl_d = CTRL_WIDTH'(ctrl_w);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_FETCH;
      boot_q  <= 1'b0;
      wait_q  <= 8'd0;
      op_q    <= 6'd0;
      fn_q    <= 6'd0;
      zero_q  <= 1'b0;
      ill_q   <= 1'b0;
      to_q    <= 1'b0;
      ret_q   <= '0;
      ctrl_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      boot_q  <= boot_d;
      wait_q  <= wait_d;
      op_q    <= op_d;
      fn_q    <= fn_d;
      zero_q  <= zero_d;
      ill_q   <= ill_d;
      to_q    <= to_d;
      ret_q   <= ret_d;
      ctrl_q  <= ctrl_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  assign CTRL    = ctrl_q;
  assign READ    = rd_q;
  assign WRITE   = wr_q;
  assign STATE   = state_q;
  assign ILLEGAL = ill_q;
  assign TIMEOUT = to_q;
  assign RETIRED = ret_q;

endmodule

// File: tb/tb_mc_ctrl_sequencer.sv
// tb/tb_mc_ctrl_sequencer.sv - table and scoreboard bench for mc_ctrl_sequencer
module tb_mc_ctrl_sequencer;

  localparam logic [2:0] FE = 3'b000, DE = 3'b001, EX = 3'b010, ME = 3'b011, WB = 3'b100, HL = 3'b111;
  localparam logic [31:0] ADD = 32'h0022_1820, LW = 32'h8C22_0004, BEQ = 32'h1022_0003;
  localparam logic [31:0] BNE = 32'h1422_0003, SW = 32'hAC22_0004, JMP = 32'h0800_0010;
  localparam logic [31:0] ILL = 32'hFC00_0000, FW = 32'h2000_0020;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst;
  logic        ack, zero;

  logic [31:0] a_ctrl, b_ctrl;
  logic        a_rd, a_wr, a_ill, a_to, b_rd, b_wr, b_ill, b_to;
  logic [2:0]  a_st, b_st;
  logic [15:0] a_ret;
  logic [3:0]  b_ret;

  int total = 0;
  int bad   = 0;
  int vidx  = 0;

  always #5 clk = ~clk;

  mc_ctrl_sequencer #(.WAIT_MAX(3)) u_a (
    .CLK(clk), .RST(rst_n), .INSTRUCTION(inst), .MEM_ACK(ack), .ZERO(zero),
    .CTRL(a_ctrl), .READ(a_rd), .WRITE(a_wr), .STATE(a_st),
    .ILLEGAL(a_ill), .TIMEOUT(a_to), .RETIRED(a_ret)
  );

  mc_ctrl_sequencer #(.HALT_ON_ILLEGAL(0), .SKIP_MEM(0), .CNT_WIDTH(4)) u_b (
    .CLK(clk), .RST(rst_n), .INSTRUCTION(inst), .MEM_ACK(ack), .ZERO(zero),
    .CTRL(b_ctrl), .READ(b_rd), .WRITE(b_wr), .STATE(b_st),
    .ILLEGAL(b_ill), .TIMEOUT(b_to), .RETIRED(b_ret)
  );

  typedef struct {
    logic [31:0] inst;
    logic        ack;
    logic        zero;
    logic [2:0]  st;
    logic        cc;
    logic [31:0] ctrl;
    logic        rd;
    logic        wr;
    logic [15:0] ret;
    logic        ill;
    logic        to;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  function automatic vec_t mk(input logic [31:0] i, input logic a, input logic z,
                              input logic [2:0] s, input logic cc, input logic [31:0] c,
                              input logic rd, input logic wr, input logic [15:0] r,
                              input logic il, input logic to);
    vec_t v;
    v.inst = i; v.ack = a; v.zero = z; v.st = s; v.cc = cc; v.ctrl = c;
    v.rd = rd; v.wr = wr; v.ret = r; v.ill = il; v.to = to;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s @vec %0d: got %h want %h", nm, idx, got, want);
    end
  endtask

  task automatic observe(input int which);
    vec_t e;
    logic [31:0] c;
    logic [2:0]  s;
    logic        rd, wr, il, to;
    logic [15:0] r;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard_empty @vec %0d: got 0 entries want 1", vidx);
      return;
    end
    e = sb.pop_front();
    if (which == 0) begin
      c = a_ctrl; s = a_st; rd = a_rd; wr = a_wr; il = a_ill; to = a_to; r = a_ret;
    end else begin
      c = b_ctrl; s = b_st; rd = b_rd; wr = b_wr; il = b_ill; to = b_to; r = {12'd0, b_ret};
    end
    chk("state", vidx, 32'(s), 32'(e.st));
    if (e.cc) chk("ctrl", vidx, c, e.ctrl);
    chk("read", vidx, 32'(rd), 32'(e.rd));
    chk("write", vidx, 32'(wr), 32'(e.wr));
    chk("retired", vidx, 32'(r), 32'(e.ret));
    chk("illegal", vidx, 32'(il), 32'(e.ill));
    chk("timeout", vidx, 32'(to), 32'(e.to));
    vidx++;
  endtask

  task automatic step(input int which, input vec_t v);
    inst = v.inst; ack = v.ack; zero = v.zero;
    sb.push_back(v);
    @(posedge clk); #1;
    observe(which);
  endtask

  // Asserts reset away from a clock edge, checks reset values, releases after the next edge.
  task automatic do_reset(input int which);
    rst_n = 1'b0;
    #1;
    sb.push_back(mk(32'h0, 1'b0, 1'b0, FE, 1'b1, 32'h0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0));
    observe(which);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; inst = 32'h0; ack = 1'b0; zero = 1'b0;

    // add, lw with MEM wait, beq/bne both ways, sw, jmp; ack during WB/DECODE/EXE must be ignored
    tbl.push_back(mk(ADD, 1, 0, FE, 1, FW,           1, 0, 16'd0, 0, 0));
    tbl.push_back(mk(ADD, 1, 0, DE, 1, 32'h110,      0, 0, 16'd0, 0, 0));
    tbl.push_back(mk(0,   0, 0, EX, 1, 32'h00601500, 0, 0, 16'd0, 0, 0));
    tbl.push_back(mk(0,   0, 0, WB, 1, 32'h0060930B, 0, 0, 16'd0, 0, 0));
    tbl.push_back(mk(LW,  1, 0, FE, 1, FW,           1, 0, 16'd1, 0, 0));
    tbl.push_back(mk(LW,  1, 0, DE, 1, 32'h110,      0, 0, 16'd1, 0, 0));
    tbl.push_back(mk(ADD, 0, 0, EX, 1, 32'h00481500, 0, 0, 16'd1, 0, 0));
    tbl.push_back(mk(ADD, 0, 0, ME, 1, 32'h00481520, 1, 0, 16'd1, 0, 0));
    tbl.push_back(mk(0,   0, 0, ME, 1, 32'h00481520, 1, 0, 16'd1, 0, 0));
    tbl.push_back(mk(0,   0, 0, ME, 1, 32'h00481520, 1, 0, 16'd1, 0, 0));
    tbl.push_back(mk(0,   1, 0, WB, 1, 32'h0048B70B, 0, 0, 16'd1, 0, 0));
    tbl.push_back(mk(BEQ, 1, 0, FE, 1, FW,           1, 0, 16'd2, 0, 0));
    tbl.push_back(mk(BEQ, 1, 0, DE, 1, 32'h110,      0, 0, 16'd2, 0, 0));
    tbl.push_back(mk(0,   0, 0, EX, 0, 32'h0,        0, 0, 16'd2, 0, 0));
    tbl.push_back(mk(0,   0, 1, WB, 1, 32'h00A0150D, 0, 0, 16'd2, 0, 0));
    tbl.push_back(mk(BEQ, 1, 0, FE, 1, FW,           1, 0, 16'd3, 0, 0));
    tbl.push_back(mk(BEQ, 1, 1, DE, 1, 32'h110,      0, 0, 16'd3, 0, 0));
    tbl.push_back(mk(0,   0, 1, EX, 0, 32'h0,        0, 0, 16'd3, 0, 0));
    tbl.push_back(mk(0,   0, 0, WB, 1, 32'h00A0150B, 0, 0, 16'd3, 0, 0));
    tbl.push_back(mk(BNE, 1, 1, FE, 1, FW,           1, 0, 16'd4, 0, 0));
    tbl.push_back(mk(BNE, 1, 0, DE, 1, 32'h110,      0, 0, 16'd4, 0, 0));
    tbl.push_back(mk(0,   0, 0, EX, 0, 32'h0,        0, 0, 16'd4, 0, 0));
    tbl.push_back(mk(0,   0, 1, WB, 1, 32'h00A0150B, 0, 0, 16'd4, 0, 0));
    tbl.push_back(mk(SW,  1, 0, FE, 1, FW,           1, 0, 16'd5, 0, 0));
    tbl.push_back(mk(SW,  1, 0, DE, 1, 32'h110,      0, 0, 16'd5, 0, 0));
    tbl.push_back(mk(0,   1, 0, EX, 1, 32'h00480100, 0, 0, 16'd5, 0, 0));
    tbl.push_back(mk(0,   1, 0, ME, 1, 32'h00480140, 0, 1, 16'd5, 0, 0));
    tbl.push_back(mk(0,   1, 0, WB, 1, 32'h0000000B, 0, 0, 16'd5, 0, 0));
    tbl.push_back(mk(JMP, 1, 0, FE, 1, FW,           1, 0, 16'd6, 0, 0));
    tbl.push_back(mk(JMP, 1, 0, DE, 1, 32'h110,      0, 0, 16'd6, 0, 0));
    tbl.push_back(mk(0,   0, 0, EX, 1, 32'h0,        0, 0, 16'd6, 0, 0));
    tbl.push_back(mk(0,   0, 0, WB, 1, 32'h00000801, 0, 0, 16'd6, 0, 0));
    tbl.push_back(mk(ILL, 1, 0, FE, 1, FW,           1, 0, 16'd7, 0, 0));

    #3;
    do_reset(0);
    for (int i = 0; i < tbl.size(); i++) step(0, tbl[i]);

    // illegal opcode halts; sticky flag, no retire, HALT holds
    step(0, mk(ILL, 1, 0, DE, 1, 32'h110, 0, 0, 16'd7, 0, 0));
    step(0, mk(0,   0, 0, HL, 1, 32'h0,   0, 0, 16'd7, 1, 0));
    step(0, mk(0,   1, 0, HL, 1, 32'h0,   0, 0, 16'd7, 1, 0));
    step(0, mk(ADD, 1, 0, HL, 1, 32'h0,   0, 0, 16'd7, 1, 0));

    // FETCH timeout after WAIT_MAX=3 wait cycles, then a clean restart
    do_reset(0);
    step(0, mk(0, 0, 0, FE, 1, FW,   1, 0, 16'd0, 0, 0));
    step(0, mk(0, 0, 0, FE, 1, FW,   1, 0, 16'd0, 0, 0));
    step(0, mk(0, 0, 0, FE, 1, FW,   1, 0, 16'd0, 0, 0));
    step(0, mk(0, 0, 0, HL, 1, 32'h0, 0, 0, 16'd0, 0, 1));
    step(0, mk(0, 1, 0, HL, 1, 32'h0, 0, 0, 16'd0, 0, 1));
    do_reset(0);
    step(0, mk(0,   0, 0, FE, 1, FW,            1, 0, 16'd0, 0, 0));
    step(0, mk(0,   0, 0, FE, 1, FW,            1, 0, 16'd0, 0, 0));
    step(0, mk(0,   0, 0, FE, 1, FW,            1, 0, 16'd0, 0, 0));
    // ack on the last allowed wait cycle still fetches
    step(0, mk(ADD, 1, 0, DE, 1, 32'h110,       0, 0, 16'd0, 0, 0));
    step(0, mk(0,   0, 0, EX, 1, 32'h00601500,  0, 0, 16'd0, 0, 0));
    step(0, mk(0,   0, 0, WB, 1, 32'h0060930B,  0, 0, 16'd0, 0, 0));
    step(0, mk(0,   0, 0, FE, 1, FW,            1, 0, 16'd1, 0, 0));

    // u_b: illegal runs as NOP through MEM, RETIRED wraps at 16
    do_reset(1);
    step(1, mk(0, 0, 0, FE, 1, FW, 1, 0, 16'd0, 0, 0));
    for (int k = 1; k <= 17; k++) begin
      step(1, mk(ILL, 1, 0, DE, 1, 32'h110,    0, 0, 16'((k - 1) % 16), 0, 0));
      step(1, mk(0,   0, 0, EX, 0, 32'h0,      0, 0, 16'((k - 1) % 16), 0, 0));
      step(1, mk(0,   0, 0, ME, 0, 32'h0,      0, 0, 16'((k - 1) % 16), 0, 0));
      step(1, mk(0,   0, 0, WB, 1, 32'h0000000B, 0, 0, 16'((k - 1) % 16), 0, 0));
      step(1, mk(0,   0, 0, FE, 1, FW,         1, 0, 16'(k % 16), 0, 0));
    end

    // u_b: reset in the middle of an sw MEM wait drops WRITE at once
    step(1, mk(SW, 1, 0, DE, 1, 32'h110,      0, 0, 16'd1, 0, 0));
    step(1, mk(0,  0, 0, EX, 1, 32'h00480100, 0, 0, 16'd1, 0, 0));
    step(1, mk(0,  0, 0, ME, 1, 32'h00480140, 0, 1, 16'd1, 0, 0));
    step(1, mk(0,  0, 0, ME, 1, 32'h00480140, 0, 1, 16'd1, 0, 0));
    #3;
    do_reset(1);
    step(1, mk(0, 0, 0, FE, 1, FW, 1, 0, 16'd0, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_sequencer.md
Name: mc_ctrl_sequencer

Overview:
Parametrised multi-cycle control sequencer for the CS147DV processor, and the next generation of the current fixed five-state control unit. It runs FETCH/DECODE/EXE/MEM/WB and drives the control word and the memory READ/WRITE strobes. It adds four things: a memory-acknowledge handshake with wait states and timeout, MEM-stage skipping for non-memory instructions, a halting illegal-opcode trap, and a retired-instruction counter.

Parameters:
CTRL_WIDTH, 32, width of CTRL; words below are zero-extended or truncated to fit.
INST_WIDTH, 32, instruction width; opcode = INST[INST_WIDTH-1 -: 6], funct = INST[5:0].
WAIT_MAX, 15, max cycles waiting for MEM_ACK in FETCH or MEM before timeout (1..255).
SKIP_MEM, 1, 1 = non-memory instructions go EXE->WB; 0 = every instruction passes through MEM for 1 cycle.
HALT_ON_ILLEGAL, 1, 1 = unknown opcode/funct halts; 0 = treated as NOP.
CNT_WIDTH, 16, width of RETIRED.

Ports:
CLK  in  1  clock, rising edge.
RST  in  1  asynchronous, active-low reset.
INSTRUCTION  in  INST_WIDTH  instruction bus; sampled only on the FETCH exit edge.
MEM_ACK  in  1  memory completion for the current READ/WRITE.
ZERO  in  1  ALU zero flag; sampled on the EXE exit edge.
CTRL  out  CTRL_WIDTH  registered control word.
READ  out  1  registered memory read strobe.
WRITE  out  1  registered memory write strobe.
STATE  out  3  current state (project PROC_* codes; HALT = 3'b111).
ILLEGAL  out  1  sticky; set when an illegal instruction is trapped.
TIMEOUT  out  1  sticky; set on MEM_ACK timeout.
RETIRED  out  CNT_WIDTH  instructions completed.

Behaviour:
- Reset (RST=0, async): CTRL=0, READ=0, WRITE=0, ILLEGAL=0, TIMEOUT=0, RETIRED=0, wait counter=0, latched instruction=0, STATE=FETCH with outputs inactive. The first rising edge after RST=1 loads the FETCH outputs. Reset mid-instruction aborts immediately; the instruction does not retire.
- All outputs are registered and update on the same edge as STATE (Moore).
- FETCH: CTRL=0x20000020, READ=1, WRITE=0.
  - On an edge with MEM_ACK=1: latch INSTRUCTION, go to DECODE.
  - Otherwise increment the wait counter; when it reaches WAIT_MAX, set TIMEOUT and go to HALT.
  - The wait counter clears on every state change.
- DECODE (1 cycle): CTRL=0x00000110, READ=WRITE=0.
  - Decode uses the latched instruction only; the live INSTRUCTION bus is ignored after FETCH.
  - Illegal instruction with HALT_ON_ILLEGAL=1: set ILLEGAL, go to HALT. Otherwise go to EXE.
  - Legal set: R-type funct 0x20,22,2C,24,25,27,2A,01,02,08,00; opcodes 0x08,1D,0C,0D,0A,0F,04,05,1B,1C,23,2B,02,03.
- EXE (1 cycle): CTRL = per-opcode EXE word from the processor control-word table (e.g. add 0x00601500, lw 0x00481500, sw 0x00480100, push 0x10920180, pop 0x005A0100, jmp 0x0). Latch ZERO.
  - Next state is MEM for memory ops (0x23, 0x2B, 0x1B, 0x1C), or for any op when SKIP_MEM=0; otherwise WB.
- MEM:
  - lw/pop: READ=1 (lw CTRL 0x00481520, pop 0x005A0120).
  - sw/push: WRITE=1 (sw 0x00480140, push 0x109201C0).
  - Memory ops hold until MEM_ACK=1, with the same timeout rule as FETCH; strobes stay asserted throughout the wait.
  - Non-memory ops (SKIP_MEM=0 only): hold the EXE word with strobes 0 for exactly 1 cycle, no ack needed.
- WB (1 cycle): READ=WRITE=0; CTRL = per-opcode WB word (add 0x0060930B, lw 0x0048B70B, jmp 0x00000801, jal 0x00000A01, NOP/default 0x0000000B).
  - beq: 0x00A0150D if latched ZERO=1, else 0x00A0150B. bne: the inverse.
  - Exit edge goes to FETCH and increments RETIRED (wraps modulo 2^CNT_WIDTH).
- HALT: CTRL=0, READ=WRITE=0; stays in HALT until reset. Sticky flags hold their value.
- Latency with immediate ack: 4 cycles for non-memory instructions (SKIP_MEM=1), 5 cycles for memory instructions; each wait cycle adds 1.
- MEM_ACK outside FETCH and memory-op MEM is ignored.

Test Plan:
- Reset, then add (0x00221820) with MEM_ACK tied 1 -> STATE sequence FETCH, DECODE, EXE, WB; CTRL 0x20000020, 0x00000110, 0x00601500, 0x0060930B; RETIRED=1 after 4 cycles.
- lw (0x8C220004), MEM_ACK low for 2 cycles in MEM -> READ=1 and CTRL=0x00481520 held for 3 cycles, then WB 0x0048B70B; RETIRED=1.
- beq with ZERO=1 at EXE exit and ZERO=0 during WB -> WB CTRL=0x00A0150D; repeat with ZERO=0 at EXE exit -> 0x00A0150B.
- Opcode 0x3F with HALT_ON_ILLEGAL=1 -> ILLEGAL=1, STATE=3'b111, CTRL=0, RETIRED unchanged; same opcode with HALT_ON_ILLEGAL=0 -> WB 0x0000000B, RETIRED increments.
- MEM_ACK stuck 0 in FETCH, WAIT_MAX=3 -> TIMEOUT=1 and HALT after 3 wait cycles; RST pulse low -> all outputs at reset values, clean FETCH.
- CNT_WIDTH=4, SKIP_MEM=0: retire 17 NOPs -> every NOP passes MEM (5 cycles each), RETIRED wraps to 1; reset asserted during MEM of an sw -> WRITE drops immediately, no retire.
